sys_pll_lock_ctrl: RTL and testbench

- Sequences the system PLL's reset and supervises its lock output.
- Holds the PLL in reset for a fixed time, then waits for lock with a timeout and retry limit.
- Requires lock to stay stable before releasing the downstream system reset.
- Re-sequences on loss of lock, counts loss events, and raises a sticky fault after repeated lock failures.
- Sits between the board reference clock/reset and the PLL instance plus all logic it clocks.

---
 rtl/sys_pll_lock_ctrl.sv | 126 ++++++++++++
 tb/tb_sys_pll_lock_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_pll_lock_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses pll_rst, waits for a stable
// synchronized lock, then releases sys_rst; retries, counts losses, and latches a fault.
module sys_pll_lock_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clr_fault,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] timer;
   logic [3:0]       retry_nx;
   logic [3:0]       retry_inc;
   logic [7:0]       loss_nx;
   logic             sync1;
   logic             lk;

   // Raw pll_locked is asynchronous; only lk may be used by the sequencer.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         lk    <= 1'b0;
      end else begin
         sync1 <= pll_locked;
         lk    <= sync1;
      end
   end

   assign retry_inc = retry_cnt + 4'd1;

   always_comb begin
      state_nx = state;
      retry_nx = retry_cnt;
      loss_nx  = loss_cnt;
      case (state)
         S_RESET: begin
            if (timer == RST_LAST) state_nx = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            // A lock arriving on the timeout cycle takes priority over the retry.
            if (lk) begin
               state_nx = S_STABLE;
            end else if (timer == TIMEOUT_LAST) begin
               retry_nx = retry_inc;
               state_nx = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
            end
         end
         S_STABLE: begin
            if (!lk) begin
               retry_nx = retry_inc;
               state_nx = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
            end else if (timer == STABLE_LAST) begin
               retry_nx = '0;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (!lk) begin
               if (loss_cnt != 8'hFF) loss_nx = loss_cnt + 8'd1;
               state_nx = S_RESET;
            end
         end
         S_FAULT: begin
            if (clr_fault) begin
               retry_nx = '0;
               state_nx = S_RESET;
            end
         end
         default: state_nx = S_RESET;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= S_RESET;
         timer     <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else begin
         state     <= state_nx;
         retry_cnt <= retry_nx;
         loss_cnt  <= loss_nx;
         if (state_nx != state) begin
            timer <= '0;
         end else if (timer != '1) begin
            timer <= timer + CNT_W'(1);
         end
         pll_rst <= (state_nx == S_RESET) || (state_nx == S_FAULT);
         sys_rst <= (state_nx != S_RUN);
         ready   <= (state_nx == S_RUN);
         fault   <= (state_nx == S_FAULT);
      end
   end

endmodule

// File: tb/tb_sys_pll_lock_ctrl.sv
// Bench for sys_pll_lock_ctrl: directed scenarios with randomized lock timing,
// checked every cycle against a phase/age reference model.
module tb_sys_pll_lock_ctrl;
   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b0;
   logic       clr_fault = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;

   int checks = 0;
   int failures = 0;

   sys_pll_lock_ctrl #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRIES(MAX_RETRIES), .CNT_W(20)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clr_fault(clr_fault),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
      .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
   );

   always #5 refclk = ~refclk;

   // Reference model: which phase of the bring-up we are in and how long we have been there.
   typedef enum int {P_HOLD, P_SEEK, P_SETTLE, P_RUN, P_FAULT} phase_e;
   phase_e m_phase;
   int     m_age;
   int     m_retry;
   int     m_loss;
   bit     m_hist[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_HOLD;
      m_age   = 0;
      m_retry = 0;
      m_loss  = 0;
      m_hist  = '{1'b0, 1'b0};
   endtask

   task automatic enter(input phase_e p);
      m_phase = p;
      m_age   = 0;
   endtask

   task automatic lost_attempt();
      m_retry++;
      if (m_retry == MAX_RETRIES) enter(P_FAULT);
      else enter(P_HOLD);
   endtask

   // The sequencer sees pll_locked as it was two edges earlier.
   task automatic model_step();
      bit lk_seen;
      lk_seen = m_hist.pop_front();
      m_hist.push_back(pll_locked);
      case (m_phase)
         P_HOLD:   if (m_age == RST_CYCLES - 1) enter(P_SEEK); else m_age++;
         P_SEEK:   if (lk_seen) enter(P_SETTLE);
                   else if (m_age == LOCK_TIMEOUT - 1) lost_attempt();
                   else m_age++;
         P_SETTLE: if (!lk_seen) lost_attempt();
                   else if (m_age == STABLE_CYCLES - 1) begin m_retry = 0; enter(P_RUN); end
                   else m_age++;
         P_RUN:    if (!lk_seen) begin if (m_loss < 255) m_loss++; enter(P_HOLD); end
         P_FAULT:  if (clr_fault) begin m_retry = 0; enter(P_HOLD); end
         default:  enter(P_HOLD);
      endcase
   endtask

   task automatic compare_all();
      check("pll_rst", 32'(pll_rst), 32'(m_phase == P_HOLD || m_phase == P_FAULT));
      check("sys_rst", 32'(sys_rst), 32'(m_phase != P_RUN));
      check("ready", 32'(ready), 32'(m_phase == P_RUN));
      check("fault", 32'(fault), 32'(m_phase == P_FAULT));
      check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge refclk);
         model_step();
         #1;
         compare_all();
      end
   endtask

   // Asserts rst between edges, checks reset values with no clock edge, releases on a negedge.
   task automatic apply_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      clr_fault = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge refclk);
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget, input string tag);
      int n;
      n = 0;
      while (!ready && n < budget) begin cyc(1); n++; end
      check(tag, 32'(ready), 32'd1);
   endtask

   initial begin
      int n;
      int hold;
      #2;
      // Nominal bring-up.
      apply_reset();
      n = 0;
      do begin cyc(1); n++; end while (pll_rst && n < 50);
      check("pll_rst_edges", 32'(n), 32'(RST_CYCLES));
      cyc(9);
      pll_locked = 1'b1;
      n = 0;
      do begin cyc(1); n++; end while (sys_rst && n < 100);
      // Counted from the edge that samples the rising pll_locked, inclusive.
      check("lock_to_release", 32'(n), 32'(STABLE_CYCLES + 3));
      check("nominal_ready", 32'(ready), 32'd1);
      check("nominal_retry", 32'(retry_cnt), 32'd0);
      clr_fault = 1'b1;
      cyc(1);
      clr_fault = 1'b0;
      cyc(5);
      check("clr_in_run_ignored", 32'(ready), 32'd1);

      // Timeout on the first attempt, lock during the second.
      apply_reset();
      n = 0;
      while (!(m_phase == P_SEEK && m_retry == 1) && n < 200) begin cyc(1); n++; end
      check("second_attempt_retry", 32'(retry_cnt), 32'd1);
      cyc($urandom_range(0, 15));
      pll_locked = 1'b1;
      wait_ready(100, "retry_run");
      check("retry_cleared", 32'(retry_cnt), 32'd0);

      // Lock never arrives: fault, then clear.
      apply_reset();
      n = 0;
      while (!fault && n < 200) begin cyc(1); n++; end
      check("fault_set", 32'(fault), 32'd1);
      check("fault_retry", 32'(retry_cnt), 32'(MAX_RETRIES));
      cyc($urandom_range(50, 80));
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_pll_rst", 32'(pll_rst), 32'd1);
      clr_fault = 1'b1;
      cyc(1);
      clr_fault = 1'b0;
      check("fault_clear", 32'(fault), 32'd0);
      check("clr_retry", 32'(retry_cnt), 32'd0);
      check("clr_reenter_reset", 32'(pll_rst), 32'd1);
      pll_locked = 1'b1;
      wait_ready(100, "after_clr_run");

      // Glitch while lock is settling.
      apply_reset();
      pll_locked = 1'b1;
      n = 0;
      while (!(m_phase == P_SETTLE && m_age == 5) && n < 100) begin cyc(1); n++; end
      pll_locked = 1'b0;
      cyc(3);
      pll_locked = 1'b1;
      check("glitch_retry", 32'(retry_cnt), 32'd1);
      check("glitch_sys_rst", 32'(sys_rst), 32'd1);
      wait_ready(100, "glitch_recover");

      // Repeated lock losses from RUN; loss_cnt must saturate.
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         n = 0;
         do begin cyc(1); n++; end while (!sys_rst && n < 10);
         check("loss_latency", 32'(n), 32'd3);
         hold = $urandom_range(0, 2);
         cyc(hold);
         pll_locked = 1'b1;
         wait_ready(100, "loss_relock");
      end
      check("loss_saturated", 32'(loss_cnt), 32'd255);

      // Asynchronous reset in the middle of the settling phase.
      pll_locked = 1'b0;
      n = 0;
      while (m_phase != P_HOLD && n < 20) begin cyc(1); n++; end
      pll_locked = 1'b1;
      hold = $urandom_range(1, 6);
      n = 0;
      while (!(m_phase == P_SETTLE && m_age == hold) && n < 100) begin cyc(1); n++; end
      #2;
      apply_reset();
      check("async_loss_cleared", 32'(loss_cnt), 32'd0);
      check("async_sys_rst", 32'(sys_rst), 32'd1);
      cyc($urandom_range(4, 12));
      pll_locked = 1'b1;
      wait_ready(100, "restart_run");
      check("restart_loss", 32'(loss_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
